lsu: RTL and testbench

Load/store unit for LemonPC. It services the `mem_ren` / `mem_wen` / `mem_mask` requests produced by instruction decode. It issues a single 64-bit, byte-strobed transaction on the data-memory bus, then returns aligned and extended load data (or store completion) to the core. It sits between the execute stage (address from ALU, store data from rs2) and the data-memory port.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu.sv | 124 ++++++++++++
 tb/tb_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LemonPC load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment: store shift/strobe, request legality, and load
// shift/truncate/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      off,
  input  logic [7:0]      mask,
  input  logic            ren,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata_sh,
  output logic            legal,
  input  logic [2:0]      ld_off,
  input  logic [7:0]      ld_mask,
  input  logic            ld_signed,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [15:0]     strb_wide;
  logic            mask_ok;
  logic [XLEN-1:0] ld_sh;

  always_comb begin
    // Upper byte of the widened strobe catches accesses crossing a doubleword.
    strb_wide = {8'h00, mask} << off;
    wstrb     = strb_wide[7:0];
    mask_ok   = (mask == MASK_B) || (mask == MASK_H) ||
                (mask == MASK_W) || (mask == MASK_D);
    legal     = mask_ok && (strb_wide[15:8] == 8'h00) && !(ren && wen);
    wdata_sh  = wdata << {off, 3'b000};
  end

  always_comb begin
    ld_sh = bus_rdata >> {ld_off, 3'b000};
    case (ld_mask)
      MASK_B:  ld_data = {{(XLEN-8){ld_signed & ld_sh[7]}},   ld_sh[7:0]};
      MASK_H:  ld_data = {{(XLEN-16){ld_signed & ld_sh[15]}}, ld_sh[15:0]};
      MASK_W:  ld_data = {{(XLEN-32){ld_signed & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// LemonPC load/store unit: accepts one core request, runs a single byte-strobed
// 64-bit bus transaction, and returns aligned/extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [7:0]        mem_mask,
  input  logic              ld_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_rsp_valid,
  output logic              bus_rsp_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_rsp_err
);

  lsu_state_e      state, state_nxt;
  logic            accept;
  logic            legal;
  logic [7:0]      wstrb_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] ld_data;

  logic [2:0]      ld_off_q;
  logic [7:0]      ld_mask_q;
  logic            ld_sgn_q;
  logic            is_ld_q;
  logic            err_q;

  assign accept = req_valid && (state == LSU_IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .off       (addr[2:0]),
    .mask      (mem_mask),
    .ren       (mem_ren),
    .wen       (mem_wen),
    .wdata     (wdata),
    .wstrb     (wstrb_c),
    .wdata_sh  (wdata_c),
    .legal     (legal),
    .ld_off    (ld_off_q),
    .ld_mask   (ld_mask_q),
    .ld_signed (ld_sgn_q),
    .bus_rdata (bus_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (accept) begin
        if (!legal || (!mem_ren && !mem_wen)) state_nxt = LSU_DONE;
        else                                  state_nxt = LSU_REQ;
      end
      LSU_REQ:  if (bus_req_ready) state_nxt = LSU_RSP;
      LSU_RSP:  if (bus_rsp_valid) state_nxt = LSU_DONE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == LSU_IDLE);
    bus_req_valid = (state == LSU_REQ);
    bus_rsp_ready = (state == LSU_RSP);
    resp_valid    = (state == LSU_DONE);
    resp_err      = (state == LSU_DONE) && err_q;
  end

  // Bus-side fields are captured pre-aligned at accept so they stay stable
  // through any number of wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      ld_off_q  <= '0;
      ld_mask_q <= '0;
      ld_sgn_q  <= 1'b0;
      is_ld_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
        bus_we    <= mem_wen;
        bus_wstrb <= mem_wen ? wstrb_c : 8'h00;
        bus_wdata <= wdata_c;
        ld_off_q  <= addr[2:0];
        ld_mask_q <= mem_mask;
        ld_sgn_q  <= ld_signed;
        is_ld_q   <= mem_ren;
        err_q     <= !legal;
      end
      if ((state == LSU_RSP) && bus_rsp_valid) begin
        err_q <= bus_rsp_err;
        if (is_ld_q && !bus_rsp_err) rdata <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized transactions
// against a byte-level reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, mem_ren, mem_wen, ld_signed;
  logic [7:0]  mem_mask;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        resp_valid, resp_err;
  logic [63:0] rdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
  logic [63:0] bus_rdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_rdata = '0;

  always #5 clk = ~clk;

  lsu #(.XLEN(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .ld_signed(ld_signed), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_ready(bus_rsp_ready), .bus_rdata(bus_rdata),
    .bus_rsp_err(bus_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mask_bytes(input logic [7:0] m);
    case (m)
      8'h01:   return 1;
      8'h03:   return 2;
      8'h0F:   return 4;
      8'hFF:   return 8;
      default: return 0;
    endcase
  endfunction

  // One full transaction; bus slave behaviour is supplied by the caller.
  task automatic run_txn(input logic ren, input logic wen, input logic [7:0] m,
                         input logic sgn, input logic [31:0] a, input logic [63:0] wd,
                         input int req_wait, input int rsp_wait,
                         input logic [63:0] brd, input logic berr);
    int          n, off, lim;
    logic        illegal;
    logic [63:0] e_strb, e_wdata, v, keep;

    n       = mask_bytes(m);
    off     = int'(a[2:0]);
    illegal = (ren && wen) || (n == 0) || (off + n > 8);
    e_strb  = wen ? ((64'd1 << n) - 64'd1) << off : 64'd0;
    e_wdata = wd << (8 * off);

    lim = 0;
    while (!req_ready && lim < 20) begin step(); lim++; end
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);

    req_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_mask = m;
    ld_signed = sgn; addr = a; wdata = wd;
    step();
    req_valid = 1'b0;
    chk("req_ready_busy", {63'd0, req_ready}, 64'd0);

    if (illegal || (!ren && !wen)) begin
      chk("nobus_req_valid", {63'd0, bus_req_valid}, 64'd0);
      chk("nobus_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("nobus_resp_err", {63'd0, resp_err}, {63'd0, illegal});
      chk("nobus_rdata", rdata, exp_rdata);
    end else begin
      for (int i = 0; i <= req_wait; i++) begin
        chk("req_valid", {63'd0, bus_req_valid}, 64'd1);
        chk("req_addr", {32'd0, bus_addr}, {32'd0, a & 32'hFFFF_FFF8});
        chk("req_we", {63'd0, bus_we}, {63'd0, wen});
        chk("req_wstrb", {56'd0, bus_wstrb}, e_strb);
        if (wen) chk("req_wdata", bus_wdata, e_wdata);
        chk("req_no_resp", {63'd0, resp_valid}, 64'd0);
        if (i == req_wait) bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
      end
      for (int i = 0; i <= rsp_wait; i++) begin
        chk("rsp_ready", {63'd0, bus_rsp_ready}, 64'd1);
        chk("rsp_req_low", {63'd0, bus_req_valid}, 64'd0);
        chk("rsp_addr", {32'd0, bus_addr}, {32'd0, a & 32'hFFFF_FFF8});
        if (i == rsp_wait) begin
          bus_rsp_valid = 1'b1; bus_rdata = brd; bus_rsp_err = berr;
        end
        step();
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rdata = $urandom();
      end
      if (ren && !berr) begin
        v = brd >> (8 * off);
        if (n < 8) begin
          keep = (64'd1 << (8 * n)) - 64'd1;
          v    = v & keep;
          if (sgn && v[8*n-1]) v = v | ~keep;
        end
        exp_rdata = v;
      end
      chk("resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("resp_err", {63'd0, resp_err}, {63'd0, berr});
      chk("rdata", rdata, exp_rdata);
    end
    step();
    chk("resp_pulse_end", {63'd0, resp_valid}, 64'd0);
    chk("rdata_held", rdata, exp_rdata);
  endtask

  initial begin
    logic [7:0]  legal_m [4];
    logic [7:0]  m;
    logic [1:0]  op;

    legal_m = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    rst_n = 1'b0; req_valid = 0; mem_ren = 0; mem_wen = 0; mem_mask = 0;
    ld_signed = 0; addr = 0; wdata = 0; bus_req_ready = 0; bus_rsp_valid = 0;
    bus_rdata = 0; bus_rsp_err = 0;
    #12;
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_bus_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    step();

    run_txn(1, 0, 8'hFF, 0, 32'h8000_0008, 64'h0, 0, 0, 64'h1122334455667788, 0);
    run_txn(1, 0, 8'h01, 1, 32'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_8000_0000, 0);
    chk("lb_signed", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1, 0, 8'h01, 0, 32'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_8000_0000, 0);
    chk("lb_unsigned", rdata, 64'h80);
    run_txn(0, 1, 8'h03, 0, 32'h8000_0006, 64'hABCD, 0, 0, 64'h0, 0);
    run_txn(0, 1, 8'h0F, 0, 32'h8000_0006, 64'h1234_5678, 0, 0, 64'h0, 0);
    run_txn(1, 0, 8'hFF, 0, 32'h8000_0010, 64'h0, 3, 2, 64'hDEAD_BEEF_0000_0001, 1);
    chk("err_rdata_kept", rdata, 64'h80);
    run_txn(1, 1, 8'h01, 0, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0);
    run_txn(0, 0, 8'h01, 0, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0);
    run_txn(1, 0, 8'h07, 0, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0);

    // Reset while waiting for the bus response.
    req_valid = 1; mem_ren = 1; mem_wen = 0; mem_mask = 8'hFF; addr = 32'h8000_0020;
    step();
    req_valid = 0; bus_req_ready = 1;
    step();
    bus_req_ready = 0;
    chk("pre_rst_rsp_ready", {63'd0, bus_rsp_ready}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_ready", {63'd0, bus_rsp_ready}, 64'd0);
    chk("arst_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("arst_rdata", rdata, 64'd0);
    chk("arst_bus_addr", {32'd0, bus_addr}, 64'd0);
    exp_rdata = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_resp", {63'd0, resp_valid}, 64'd0);
      step();
    end

    for (int t = 0; t < 300; t++) begin
      op = 2'($urandom_range(0, 3));
      m  = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : legal_m[$urandom_range(0, 3)];
      run_txn(op[0], op[1], m, 1'($urandom()), $urandom(),
              {$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom(), $urandom()}, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
